// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Two-port arbiter and access sequencer for an asynchronous 16-bit x 256K
// SRAM. Port A is the UART loader side and port B is the CPU/datapath side.
// One request is granted at a time. The chip-enable, output-enable and
// write-enable strobes are multi-cycle and come straight from flops, so they
// cannot glitch. Read data is registered per port, and the granted port gets
// a one-cycle ack.
//
// Build option:
//   SRAM_ARB_FIXED_PRIO_EN  defined   -> port A always wins simultaneous
//                                        requests (no round-robin state)
//                           undefined -> round-robin between A and B
//
// Parameters:
//   ADDR_W     SRAM address width
//   DATA_W     SRAM data width
//   WR_CYCLES  cycles ram_we is held low per write (values below 1 act as 1)
//   RD_CYCLES  cycles ram_oe is held low before read data is captured
//              (values below 1 act as 1)
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 synchronous active-high reset
//   a_req / b_req       request, held with stable we/addr/wdata until ack
//   a_we / b_we         1 = write, 0 = read
//   a_addr / b_addr     word address
//   a_wdata / b_wdata   write data
//   a_ack / b_ack       one-cycle completion pulse
//   a_rdata / b_rdata   registered read data, held until the next read
//                       on the same port
//   ram_en              SRAM chip enable, active low
//   ram_oe              SRAM output enable, active low
//   ram_we              SRAM write enable, active low
//   ram_addr            SRAM address (registered)
//   ram_data            SRAM data bus, driven only in the write states
// ---------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,

  output logic              ram_en,
  output logic              ram_oe,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  // Clamp the strobe lengths to at least one cycle.
  localparam int WR_N    = (WR_CYCLES < 1) ? 1 : WR_CYCLES;
  localparam int RD_N    = (RD_CYCLES < 1) ? 1 : RD_CYCLES;
  localparam int CNT_MAX = (WR_N > RD_N) ? WR_N : RD_N;
  // The counter holds at most CNT_MAX-1.
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_N - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // state    | meaning
  // IDLE     | strobes high, bus Z, arbitrate and latch the winning request
  // WR_SETUP | ram_en low, address and data valid, ram_we still high
  // WR_PULSE | ram_we low for WR_CYCLES cycles
  // WR_HOLD  | ram_we back high, data still driven for hold time
  // RD       | ram_en and ram_oe low for RD_CYCLES cycles, capture on the last
  // ACK      | strobes high, one-cycle ack to the granted port
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_SETUP = 3'd1,
    WR_PULSE = 3'd2,
    WR_HOLD  = 3'd3,
    RD       = 3'd4,
    ACK      = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grant_q, grant_d;   // 0 = port A, 1 = port B
  logic              take;               // a request is accepted this cycle
  logic              sel_we;
  logic              capture;
  logic              drive_en;
  logic [DATA_W-1:0] wdata_q;

`ifndef SRAM_ARB_FIXED_PRIO_EN
  logic              rr_last_q;          // last granted port
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    take    = 1'b0;
    sel_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          take = 1'b1;
          if (a_req && b_req) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            grant_d = 1'b0;
`else
            // Give the bus to the port that was not served last.
            grant_d = ~rr_last_q;
`endif
          end else begin
            grant_d = b_req;
          end
          sel_we = grant_d ? b_we : a_we;
          if (sel_we) begin
            state_d = WR_SETUP;
          end else begin
            state_d = RD;
            cnt_d   = RD_LOAD;
          end
        end
      end

      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = WR_LOAD;
      end

      WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      WR_HOLD: begin
        state_d = ACK;
      end

      RD: begin
        if (cnt_q == '0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Last RD cycle: the SRAM output has been enabled for RD_CYCLES cycles.
  assign capture = (state_q == RD) && (cnt_q == '0);

  // Driving from the registered state keeps the write driver and ram_oe=0
  // mutually exclusive: both are functions of the same flop contents.
  assign drive_en = (state_q == WR_SETUP) || (state_q == WR_PULSE) ||
                    (state_q == WR_HOLD);

  assign ram_data = drive_en ? wdata_q : {DATA_W{1'bz}};

  // -------------------------------------------------------------------------
  // State, latched request and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      grant_q   <= 1'b0;
      wdata_q   <= '0;
      ram_addr  <= '0;
      ram_en    <= 1'b1;
      ram_oe    <= 1'b1;
      ram_we    <= 1'b1;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      rr_last_q <= 1'b1;   // B, so A wins the first contention
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;

      if (take) begin
        ram_addr  <= grant_d ? b_addr  : a_addr;
        wdata_q   <= grant_d ? b_wdata : a_wdata;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        rr_last_q <= grant_d;
`endif
      end

      // Strobes are decoded from the next state so they line up with the
      // state register without a combinational path to the pins.
      ram_en <= (state_d == IDLE) || (state_d == ACK);
      ram_oe <= (state_d != RD);
      ram_we <= (state_d != WR_PULSE);

      // ACK is only reached from WR_HOLD or RD, where grant_q is stable.
      a_ack  <= (state_d == ACK) && !grant_q;
      b_ack  <= (state_d == ACK) &&  grant_q;

      if (capture) begin
        if (grant_q) begin
          b_rdata <= ram_data;
        end else begin
          a_rdata <= ram_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: default build (WR=2, RD=2). Index 1: WR=1, RD=4.
  logic        rst     [2];
  logic        a_req   [2];
  logic        a_we    [2];
  logic [17:0] a_addr  [2];
  logic [15:0] a_wdata [2];
  logic        a_ack   [2];
  logic [15:0] a_rdata [2];
  logic        b_req   [2];
  logic        b_we    [2];
  logic [17:0] b_addr  [2];
  logic [15:0] b_wdata [2];
  logic        b_ack   [2];
  logic [15:0] b_rdata [2];
  logic        ram_en  [2];
  logic        ram_oe  [2];
  logic        ram_we  [2];
  logic [17:0] ram_addr[2];
  wire  [15:0] ram_data0;
  wire  [15:0] ram_data1;

  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];

  int n_checks = 0;
  int n_err    = 0;

  sram_arbiter dut0 (
    .clk(clk), .rst(rst[0]),
    .a_req(a_req[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
    .a_ack(a_ack[0]), .a_rdata(a_rdata[0]),
    .b_req(b_req[0]), .b_we(b_we[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
    .b_ack(b_ack[0]), .b_rdata(b_rdata[0]),
    .ram_en(ram_en[0]), .ram_oe(ram_oe[0]), .ram_we(ram_we[0]),
    .ram_addr(ram_addr[0]), .ram_data(ram_data0)
  );

  sram_arbiter #(.WR_CYCLES(1), .RD_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst[1]),
    .a_req(a_req[1]), .a_we(a_we[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
    .a_ack(a_ack[1]), .a_rdata(a_rdata[1]),
    .b_req(b_req[1]), .b_we(b_we[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
    .b_ack(b_ack[1]), .b_rdata(b_rdata[1]),
    .ram_en(ram_en[1]), .ram_oe(ram_oe[1]), .ram_we(ram_we[1]),
    .ram_addr(ram_addr[1]), .ram_data(ram_data1)
  );

  // Asynchronous SRAM models: drive the bus while selected and output-enabled,
  // store on the clock edges that see the write strobe low.
  assign ram_data0 = (!ram_en[0] && !ram_oe[0]) ? mem0[ram_addr[0][7:0]] : 16'hzzzz;
  assign ram_data1 = (!ram_en[1] && !ram_oe[1]) ? mem1[ram_addr[1][7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ram_en[0] && !ram_we[0]) mem0[ram_addr[0][7:0]] <= ram_data0;
    if (!ram_en[1] && !ram_we[1]) mem1[ram_addr[1][7:0]] <= ram_data1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bus checker: while the SRAM drives, the write strobe is high and the bus
  // carries exactly the SRAM word (any DUT drive would corrupt it).
  always @(negedge clk) begin
    if (!rst[0] && !ram_oe[0]) begin
      check("bus0_we_high", ram_we[0], 1'b1);
      check("bus0_data", ram_data0, mem0[ram_addr[0][7:0]]);
    end
    if (!rst[1] && !ram_oe[1]) begin
      check("bus1_we_high", ram_we[1], 1'b1);
      check("bus1_data", ram_data1, mem1[ram_addr[1][7:0]]);
    end
  end

  // One transaction on DUT d; entered and left at a negedge.
  task automatic txn(input int d, input bit pb, input bit we,
                     input logic [17:0] addr, input logic [15:0] wd, input string tag);
    int wrc, rdc, lat, en_lo, oe_lo, we_lo, dat_ok, addr_ok, oth;
    bit done, own, other, en, oe, wen;
    logic [15:0] bus;
    wrc = (d == 0) ? 2 : 1;
    rdc = (d == 0) ? 2 : 4;
    lat = 0; en_lo = 0; oe_lo = 0; we_lo = 0; dat_ok = 0; addr_ok = 0; oth = 0;
    done = 1'b0;
    if (pb) begin
      b_req[d] = 1'b1; b_we[d] = we; b_addr[d] = addr; b_wdata[d] = wd;
    end else begin
      a_req[d] = 1'b1; a_we[d] = we; a_addr[d] = addr; a_wdata[d] = wd;
    end
    for (int cyc = 1; cyc <= 30 && !done; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      en    = ram_en[d];
      oe    = ram_oe[d];
      wen   = ram_we[d];
      bus   = (d == 0) ? ram_data0 : ram_data1;
      own   = pb ? b_ack[d] : a_ack[d];
      other = pb ? a_ack[d] : b_ack[d];
      if (!en) en_lo++;
      if (!oe) oe_lo++;
      if (!wen) we_lo++;
      if (!en && oe && bus == wd) dat_ok++;
      if (!en && ram_addr[d] == addr) addr_ok++;
      if (other) oth++;
      if (own) begin
        lat  = cyc;
        done = 1'b1;
        if (pb) b_req[d] = 1'b0; else a_req[d] = 1'b0;
      end
    end
    check({tag, "_ack_cycle"}, lat, we ? wrc + 3 : rdc + 1);
    check({tag, "_en_low"}, en_lo, we ? wrc + 2 : rdc);
    check({tag, "_oe_low"}, oe_lo, we ? 0 : rdc);
    check({tag, "_we_low"}, we_lo, we ? wrc : 0);
    check({tag, "_data_driven"}, dat_ok, we ? wrc + 2 : 0);
    check({tag, "_addr"}, addr_ok, we ? wrc + 2 : rdc);
    check({tag, "_other_ack"}, oth, 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_ack_pulse"}, pb ? b_ack[d] : a_ack[d], 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n, dbl, both, lat, acnt;
    bit prev, aa, bb;
    int seqv[4];
    int seqc[4];

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      a_req[d] = 1'b0; a_we[d] = 1'b0; a_addr[d] = '0; a_wdata[d] = '0;
      b_req[d] = 1'b0; b_we[d] = 1'b0; b_addr[d] = '0; b_wdata[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_en", ram_en[d], 1'b1);
      check("rst_oe", ram_oe[d], 1'b1);
      check("rst_we", ram_we[d], 1'b1);
      check("rst_addr", ram_addr[d], 18'h0);
      check("rst_a_ack", a_ack[d], 1'b0);
      check("rst_b_ack", b_ack[d], 1'b0);
      check("rst_a_rdata", a_rdata[d], 16'h0);
      check("rst_b_rdata", b_rdata[d], 16'h0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);

    // Default timing on DUT0.
    txn(0, 1'b0, 1'b1, 18'h00010, 16'hBEEF, "a_wr");
    txn(0, 1'b1, 1'b1, 18'h00010, 16'h1234, "b_wr_preload");
    txn(0, 1'b1, 1'b0, 18'h00010, 16'h0000, "b_rd");
    check("b_rd_data", b_rdata[0], 16'h1234);
    check("b_rd_a_rdata_same", a_rdata[0], 16'h0);
    repeat (3) @(negedge clk);
    check("b_rdata_held", b_rdata[0], 16'h1234);
    txn(0, 1'b1, 1'b1, 18'h00020, 16'h5678, "b_wr2");
    check("b_rdata_after_wr", b_rdata[0], 16'h1234);

    // Contention: both ports read, requests held.
    a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 18'h00010;
    b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 18'h00020;
    n = 0; dbl = 0; both = 0; prev = 1'b0;
    for (int cyc = 1; cyc <= 60 && n < 4; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      aa = a_ack[0];
      bb = b_ack[0];
      if (aa || bb) begin
        if (prev) dbl++;
        if (aa && bb) both++;
        seqv[n] = bb ? 1 : 0;
        seqc[n] = cyc;
        n++;
      end
      prev = aa | bb;
    end
    a_req[0] = 1'b0;
    b_req[0] = 1'b0;
    check("ctn_ack_count", n, 4);
    check("ctn_double_ack", dbl, 0);
    check("ctn_both_ack", both, 0);
    for (int i = 0; i < n && i < 4; i++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      check("ctn_grant_order", seqv[i], 0);
`else
      check("ctn_grant_order", seqv[i], i % 2);
`endif
      if (i > 0) check("ctn_spacing", seqc[i] - seqc[i-1], 4);
    end
    repeat (2) @(negedge clk);
    check("ctn_a_rdata", a_rdata[0], 16'h1234);
`ifdef SRAM_ARB_FIXED_PRIO_EN
    check("ctn_b_rdata", b_rdata[0], 16'h1234);
`else
    check("ctn_b_rdata", b_rdata[0], 16'h5678);
`endif

    // Reset in the middle of a port A write pulse.
    a_req[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 18'h00040; a_wdata[0] = 16'hAAAA;
    acnt = 0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      if (a_ack[0]) acnt++;
    end
    check("rstmid_in_pulse", ram_we[0], 1'b0);
    rst[0] = 1'b1;
    b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 18'h00020;
    @(posedge clk);
    @(negedge clk);
    if (a_ack[0]) acnt++;
    check("rstmid_we", ram_we[0], 1'b1);
    check("rstmid_en", ram_en[0], 1'b1);
    check("rstmid_oe", ram_oe[0], 1'b1);
    check("rstmid_a_rdata", a_rdata[0], 16'h0);
    check("rstmid_b_rdata", b_rdata[0], 16'h0);
    rst[0] = 1'b0;
    a_req[0] = 1'b0;
    lat = 0;
    for (int cyc = 1; cyc <= 20 && lat == 0; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (a_ack[0]) acnt++;
      if (b_ack[0]) begin
        lat = cyc;
        b_req[0] = 1'b0;
      end
    end
    check("rstmid_b_lat", lat, 3);
    check("rstmid_b_data", b_rdata[0], 16'h5678);
    check("rstmid_no_a_ack", acnt, 0);

    // Parameter sweep on DUT1 (WR=1, RD=4).
    txn(1, 1'b0, 1'b1, 18'h00030, 16'hCAFE, "p_a_wr");
    txn(1, 1'b1, 1'b0, 18'h00030, 16'h0000, "p_b_rd");
    check("p_b_rd_data", b_rdata[1], 16'hCAFE);
    check("p_a_rdata_same", a_rdata[1], 16'h0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
